// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC, zero-latency imem addressing, small fetch FIFO toward decode.
// Optional FETCH_PERF_EN adds issue/flush performance counters.
module imem_fetch_ctrl #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fetch_en,
  input  logic             i_redirect_valid,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-3:0] o_imem_addr,
  input  logic [WIDTH-1:0] i_imem_data,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_instr_pc,
  output logic             o_misaligned,
  output logic             o_halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      o_perf_fetched,
  output logic [31:0]      o_perf_flushed
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e                           r_state, w_state_nxt;
  logic [WIDTH-1:0]                 r_pc;
  logic [FIFO_DEPTH-1:0][WIDTH-1:0] r_mem_instr;
  logic [FIFO_DEPTH-1:0][WIDTH-1:0] r_mem_pc;
  logic [AW-1:0]                    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                    r_count;
  logic [WIDTH-1:0]                 r_hold_instr, r_hold_pc;
  logic                             r_misaligned;

  logic             w_empty, w_full, w_pop, w_issue;
  logic [WIDTH-1:0] w_head_instr, w_head_pc;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_head_instr = r_mem_instr[r_rd_ptr];
  assign w_head_pc    = r_mem_pc[r_rd_ptr];
  assign w_pop        = !w_empty && i_instr_ready;

  assign o_imem_addr   = r_pc[WIDTH-1:2];
  assign o_instr_valid = !w_empty;
  // When empty, the last presented head is shown rather than stale slot contents.
  assign o_instr       = w_empty ? r_hold_instr : w_head_instr;
  assign o_instr_pc    = w_empty ? r_hold_pc    : w_head_pc;
  assign o_misaligned  = r_misaligned;
  assign o_halted      = (r_state == HALT) && w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = i_fetch_en ? RUN : HALT;
      RUN: begin
        w_issue     = i_fetch_en && (!w_full || w_pop) && !i_redirect_valid;
        w_state_nxt = i_fetch_en ? RUN : HALT;
      end
      HALT:    w_state_nxt = i_fetch_en ? RUN : HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_mem_instr  <= '0;
      r_mem_pc     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_empty) begin
        r_hold_instr <= w_head_instr;
        r_hold_pc    <= w_head_pc;
      end
      if (i_redirect_valid) begin
        // Flush wins over any same-cycle pop; pc is forced word aligned.
        r_pc     <= {i_redirect_pc[WIDTH-1:2], 2'b00};
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        if (i_redirect_pc[1:0] != 2'b00) r_misaligned <= 1'b1;
      end else begin
        if (w_issue) begin
          r_mem_instr[r_wr_ptr] <= i_imem_data;
          r_mem_pc[r_wr_ptr]    <= r_pc;
          r_wr_ptr              <= r_wr_ptr + AW'(1);
          r_pc                  <= r_pc + WIDTH'(4);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_issue, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_flushed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_issue)          r_perf_fetched <= r_perf_fetched + 32'd1;
      if (i_redirect_valid) r_perf_flushed <= r_perf_flushed + 32'(r_count);
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed table-driven bench for imem_fetch_ctrl with a formula-based instruction memory.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid, misaligned, halted;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [29:0] a);
    logic [31:0] w;
    w = {2'b00, a};
    return 32'h0000_0013 + (w << 20);
  endfunction

  always_comb imem_data = word(imem_addr);

  imem_fetch_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_en(fetch_en),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
    .o_instr(instr), .o_instr_pc(instr_pc),
    .o_misaligned(misaligned), .o_halted(halted)
`ifdef FETCH_PERF_EN
    , .o_perf_fetched(perf_fetched), .o_perf_flushed(perf_flushed)
`endif
  );

  typedef struct {
    logic        rst, fe, rv, rdy;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_addr;
    logic        e_mis, e_halt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, fe, rv, rdy, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] eipc, eaddr,
                     input logic emis, ehalt);
    vec_t v;
    v.rst = r; v.fe = fe; v.rv = rv; v.rdy = rdy; v.rpc = rpc;
    v.e_valid = ev; v.e_ipc = eipc; v.e_addr = eaddr; v.e_mis = emis; v.e_halt = ehalt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, fe, rv, rdy, input logic [31:0] rpc);
    rst = r; fetch_en = fe; redirect_valid = rv; instr_ready = rdy; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; redirect_pc = '0;

    //   rst fe rv rdy rpc            valid ipc            addr           mis halt
    add(1, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,         0, 0); // 0 reset
    add(0, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,         0, 0); // 1 BOOT
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          32'h1,         0, 0); // 2 first valid
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          32'h2,         0, 0); // 3 full
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          32'h2,         0, 0); // 4 stall
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          32'h2,         0, 0); // 5
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          32'h2,         0, 0); // 6
    add(0, 1, 0, 1, 32'h0,          1, 32'h4,          32'h3,         0, 0); // 7 drain
    add(0, 1, 0, 1, 32'h0,          1, 32'h8,          32'h4,         0, 0); // 8
    add(0, 1, 0, 0, 32'h0,          1, 32'h8,          32'h4,         0, 0); // 9 full
    add(0, 1, 1, 0, 32'h100,        0, 32'h8,          32'h40,        0, 0); // 10 redirect
    add(0, 1, 0, 0, 32'h0,          1, 32'h100,        32'h41,        0, 0); // 11
    add(0, 1, 0, 1, 32'h0,          1, 32'h104,        32'h42,        0, 0); // 12
    add(0, 1, 1, 1, 32'h102,        0, 32'h104,        32'h40,        1, 0); // 13 misaligned
    add(0, 1, 0, 1, 32'h0,          1, 32'h100,        32'h41,        1, 0); // 14
    add(0, 1, 0, 1, 32'h0,          1, 32'h104,        32'h42,        1, 0); // 15
    add(0, 0, 0, 0, 32'h0,          1, 32'h104,        32'h42,        1, 0); // 16 stop
    add(0, 0, 0, 1, 32'h0,          0, 32'h104,        32'h42,        1, 1); // 17 drained
    add(0, 0, 0, 1, 32'h0,          0, 32'h104,        32'h42,        1, 1); // 18
    add(0, 1, 0, 1, 32'h0,          0, 32'h104,        32'h42,        1, 0); // 19 to RUN
    add(0, 1, 0, 1, 32'h0,          1, 32'h108,        32'h43,        1, 0); // 20 resume
    add(0, 0, 0, 1, 32'h0,          0, 32'h108,        32'h43,        1, 1); // 21
    add(0, 0, 1, 1, 32'hFFFF_FFFC,  0, 32'h108,        32'h3FFF_FFFF, 1, 1); // 22 redirect in HALT
    add(0, 1, 0, 1, 32'h0,          0, 32'h108,        32'h3FFF_FFFF, 1, 0); // 23
    add(0, 1, 0, 1, 32'h0,          1, 32'hFFFF_FFFC,  32'h0,         1, 0); // 24
    add(0, 1, 0, 1, 32'h0,          1, 32'h0,          32'h1,         1, 0); // 25 wrap
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          32'h2,         1, 0); // 26
    add(1, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,         0, 0); // 27 reset mid-run
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,         0, 1); // 28 BOOT->HALT

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].fe, vq[i].rv, vq[i].rdy, vq[i].rpc);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vq[i].e_valid});
      chk($sformatf("v%0d_ipc", i), instr_pc, vq[i].e_ipc);
      chk($sformatf("v%0d_addr", i), {2'b00, imem_addr}, vq[i].e_addr);
      chk($sformatf("v%0d_mis", i), {31'b0, misaligned}, {31'b0, vq[i].e_mis});
      chk($sformatf("v%0d_halt", i), {31'b0, halted}, {31'b0, vq[i].e_halt});
      if (vq[i].rst)
        chk($sformatf("v%0d_instr_rst", i), instr, 32'h0);
      else if (vq[i].e_valid)
        chk($sformatf("v%0d_instr", i), instr, word(vq[i].e_ipc[31:2]));
`ifdef FETCH_PERF_EN
      if (i == 10) chk("perf_flushed_full", perf_flushed, 32'd2);
`endif
    end

    // Redirect with a same-cycle pop: the popped entry is dropped and the target follows.
    step(0, 1, 0, 1, 32'h0);
    step(0, 1, 0, 1, 32'h0);
    chk("seq_ipc0", instr_pc, 32'h0);
    step(0, 1, 0, 1, 32'h0);
    chk("seq_ipc4", instr_pc, 32'h4);
    step(0, 1, 1, 1, 32'h200);
    chk("seq_flush_valid", {31'b0, instr_valid}, 32'h0);
    step(0, 1, 0, 1, 32'h0);
    chk("seq_tgt_valid", {31'b0, instr_valid}, 32'h1);
    chk("seq_tgt_pc", instr_pc, 32'h200);
    chk("seq_tgt_instr", instr, 32'h0800_0013);
    step(0, 1, 0, 1, 32'h0);
    chk("seq_next_pc", instr_pc, 32'h204);
`ifdef FETCH_PERF_EN
    chk("seq_perf_flushed", perf_flushed, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
